// File: rtl/reset_sequencer.sv
// reset_sequencer: turns a power-on reset, a bouncing push-button reset and an
// optional software request into one clean, registered active-low reset.
// The release is held for HOLD_CYCLES clocks and flagged with a one-cycle
// rst_done pulse. rst_cause records what started the most recent reset.
// Optional feature: define RESET_SEQUENCER_SW_REQ_EN to add the sw_rst_req port.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_rst_n,
`ifdef RESET_SEQUENCER_SW_REQ_EN
  input  logic       sw_rst_req,
`endif
  output logic       rst_sync_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] DEB_MAX   = 8'(DEBOUNCE_CYCLES);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] por_chain;
  logic                   por_sync;
  logic [1:0]             btn_sync;
  logic [7:0]             deb_cnt;
  logic                   btn_hit;
  logic [7:0]             hold_cnt, hold_nxt;
  logic                   sw_req;
  logic                   rst_sync_nxt, rst_done_nxt;
  logic [1:0]             rst_cause_nxt;

`ifdef RESET_SEQUENCER_SW_REQ_EN
  assign sw_req = sw_rst_req;
`else
  assign sw_req = 1'b0;
`endif

  // Power-on release synchronizer: asynchronously cleared, shifts in ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) por_chain <= '0;
    else        por_chain <= {por_chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign por_sync = por_chain[SYNC_STAGES-1];

  // Two-flop synchronizer for the raw push-button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_sync <= '0;
    else        btn_sync <= {btn_sync[0], btn_rst_n};
  end

  // Debounce: count consecutive low samples, saturate, clear on any high sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                deb_cnt <= '0;
    else if (btn_sync[1])      deb_cnt <= '0;
    else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 8'd1;
  end

  assign btn_hit = (deb_cnt == DEB_MAX);

  // FSM state and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next state: leave HOLD after the hold count expires; a held button keeps
  // the count at zero so reset lasts until the button is let go.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    case (state)
      HOLD: begin
        if (por_sync && !btn_hit) begin
          if (hold_cnt == HOLD_LAST) state_nxt = RUN;
          else                       hold_nxt  = hold_cnt + 8'd1;
        end
      end
      RUN: begin
        if (btn_hit || sw_req) state_nxt = HOLD;
      end
      default: state_nxt = HOLD;
    endcase
  end

  // Output decode: values loaded into the output flops on the coming edge.
  // The button wins when it coincides with a software request.
  always_comb begin
    rst_sync_nxt  = (state_nxt == RUN);
    rst_done_nxt  = (state == HOLD) && (state_nxt == RUN);
    rst_cause_nxt = rst_cause;
    if (state == RUN && state_nxt == HOLD)
      rst_cause_nxt = btn_hit ? CAUSE_BTN : CAUSE_SW;
  end

  // Registered outputs; power-on reset forces the power-on cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_n <= 1'b0;
      rst_done   <= 1'b0;
      rst_cause  <= CAUSE_POR;
    end else begin
      rst_sync_n <= rst_sync_nxt;
      rst_done   <= rst_done_nxt;
      rst_cause  <= rst_cause_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: expected rst_sync_n edges (cycle, direction,
// cause) are queued when stimulus is applied and checked as the DUT makes them.
module tb_reset_sequencer;
  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_rst_n = 1'b1;
`ifdef RESET_SEQUENCER_SW_REQ_EN
  logic       sw_rst_req = 1'b0;
`endif
  logic       rst_sync_n;
  logic       rst_done;
  logic [1:0] rst_cause;

  reset_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_rst_n(btn_rst_n),
`ifdef RESET_SEQUENCER_SW_REQ_EN
    .sw_rst_req(sw_rst_req),
`endif
    .rst_sync_n(rst_sync_n),
    .rst_done(rst_done),
    .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         rise;
    int         edge_n;
    logic [1:0] cause;
  } ev_t;
  ev_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit rise, input int edge_n, input logic [1:0] cause);
    ev_t e;
    e.rise = rise; e.edge_n = edge_n; e.cause = cause;
    exp_q.push_back(e);
  endtask

  // Monitor: every rst_sync_n transition must match the head of the queue.
  bit         mon_en = 1'b0;
  logic       prev_sync = 1'b0;
  logic [1:0] run_cause = 2'b00;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_sync_n !== prev_sync) begin
        chk("event_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev_t e;
          e = exp_q.pop_front();
          chk("edge_dir", 32'(rst_sync_n), 32'(e.rise));
          chk("edge_cycle", cyc, e.edge_n);
          chk("edge_cause", 32'(rst_cause), 32'(e.cause));
          chk("done_on_edge", 32'(rst_done), 32'(e.rise));
        end
        run_cause = rst_cause;
      end else begin
        if (rst_done !== 1'b0) chk("done_spurious", 32'(rst_done), 0);
        if (rst_sync_n === 1'b1) chk("cause_stable", 32'(rst_cause), 32'(run_cause));
      end
      prev_sync = rst_sync_n;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Hold the button low for low_cycles clocks; queue the reset it should cause.
  task automatic btn_press(input int low_cycles, input bit fires);
    int base;
    @(negedge clk);
    base = cyc;
    btn_rst_n = 1'b0;
    if (fires) begin
      push_ev(1'b0, base + 3 + DEB, 2'b01);
      push_ev(1'b1, base + low_cycles + 3 + HOLD, 2'b01);
    end
    repeat (low_cycles) @(negedge clk);
    btn_rst_n = 1'b1;
    drain(80);
  endtask

  initial begin
    int base;
    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk("por_sync_n", 32'(rst_sync_n), 0);
    chk("por_done", 32'(rst_done), 0);
    chk("por_cause", 32'(rst_cause), 0);
    repeat (3) @(posedge clk);
    #1 chk("por_hold_clocked", 32'(rst_sync_n), 0);
    @(negedge clk); #2;
    base = cyc;
    rst_n = 1'b1;
    prev_sync = rst_sync_n;
    mon_en = 1'b1;
    push_ev(1'b1, base + SYNC + HOLD, 2'b00);
    drain(60);
    chk("por_run", 32'(rst_sync_n), 1);

    // Button resets: long press, threshold press, and just-too-short press
    btn_press(20, 1'b1);
    btn_press(DEB, 1'b1);
    btn_press(DEB - 1, 1'b0);
    repeat (6) @(negedge clk);
    chk("short_press_run", 32'(rst_sync_n), 1);

    // Bounce: 7 low, 1 high, 7 low never reaches the threshold
    @(negedge clk);
    btn_rst_n = 1'b0;
    repeat (7) @(negedge clk);
    btn_rst_n = 1'b1;
    @(negedge clk);
    btn_rst_n = 1'b0;
    repeat (7) @(negedge clk);
    btn_rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("bounce_sync_n", 32'(rst_sync_n), 1);
    chk("bounce_done", 32'(rst_done), 0);

`ifdef RESET_SEQUENCER_SW_REQ_EN
    // Software reset with a second pulse during HOLD that must be ignored
    @(negedge clk);
    base = cyc;
    sw_rst_req = 1'b1;
    push_ev(1'b0, base + 1, 2'b10);
    push_ev(1'b1, base + 1 + HOLD, 2'b10);
    @(negedge clk);
    sw_rst_req = 1'b0;
    repeat (4) @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    drain(60);

    // Button and software request in the same cycle: button wins
    @(negedge clk);
    base = cyc;
    btn_rst_n = 1'b0;
    push_ev(1'b0, base + 3 + DEB, 2'b01);
    push_ev(1'b1, base + 20 + 3 + HOLD, 2'b01);
    repeat (2 + DEB) @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    repeat (20 - 3 - DEB) @(negedge clk);
    btn_rst_n = 1'b1;
    drain(80);
`endif

    // Asynchronous abort in the middle of a button-initiated HOLD
    @(negedge clk);
    base = cyc;
    btn_rst_n = 1'b0;
    push_ev(1'b0, base + 3 + DEB, 2'b01);
    repeat (12) @(negedge clk);
    btn_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_pre_cause", 32'(rst_cause), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sync_n", 32'(rst_sync_n), 0);
    chk("abort_cause", 32'(rst_cause), 0);
    chk("abort_done", 32'(rst_done), 0);
    #1 rst_n = 1'b1;
    base = cyc;
    push_ev(1'b1, base + SYNC + HOLD, 2'b00);
    drain(60);
    chk("abort_run", 32'(rst_sync_n), 1);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
